// File: rtl/uart_load_ctrl.sv
// Parses A5/N/words/CHK frames from the UART byte strobe and writes words to memory.
// Outputs registered; a write follows its last byte by one cycle; no backpressure, bytes arrive at UART rate.
module uart_load_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic              busy
);

  localparam int              BYTES    = WORD_W / 8;
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [1:0]      LAST_IDX = 2'(BYTES - 1);
  localparam logic [TW-1:0]   T_TERM   = TW'(TIMEOUT - 1);
  localparam logic [7:0]      START    = 8'hA5;

  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

  state_t              state;
  logic                rx_ready_d;
  logic [7:0]          chk;
  logic [7:0]          wcnt;
  logic [1:0]          byte_idx;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-1:0]   asm_word;
  logic [WORD_W-1:0]   word_next;
  logic [TW-1:0]       tcnt;
  logic                accept;
  logic                timeout;

  assign accept  = rx_ready & ~rx_ready_d;
  assign timeout = (tcnt == T_TERM);

  // Word as it will look once the current byte lands in its lane.
  always_comb begin
    word_next = asm_word;
    word_next[{byte_idx, 3'b000} +: 8] = rx_byte;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready_d <= 1'b1;
      chk        <= '0;
      wcnt       <= '0;
      byte_idx   <= '0;
      addr       <= '0;
      asm_word   <= '0;
      tcnt       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_ready_d <= rx_ready;
      mem_we     <= 1'b0;
      load_done  <= 1'b0;
      if (state != IDLE) tcnt <= accept ? '0 : tcnt + TW'(1);

      case (state)
        IDLE: begin
          if (accept && rx_byte == START) begin
            state      <= COUNT;
            busy       <= 1'b1;
            load_error <= 1'b0;
            cpu_hold   <= 1'b1;
            chk        <= '0;
            addr       <= '0;
            tcnt       <= '0;
          end
        end

        COUNT: begin
          if (accept) begin
            wcnt     <= rx_byte;
            chk      <= rx_byte;
            byte_idx <= '0;
            state    <= (rx_byte == 8'd0) ? CHECK : DATA;
          end else if (timeout) begin
            load_error <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end

        DATA: begin
          if (accept) begin
            chk <= chk ^ rx_byte;
            if (byte_idx == LAST_IDX) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= word_next;
              addr      <= addr + ADDR_W'(1);
              wcnt      <= wcnt - 8'd1;
              byte_idx  <= '0;
              if (wcnt == 8'd1) state <= CHECK;
            end else begin
              asm_word <= word_next;
              byte_idx <= byte_idx + 2'd1;
            end
          end else if (timeout) begin
            load_error <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end

        CHECK: begin
          if (accept) begin
            // Good checksum releases the processor; a bad one leaves it held.
            if (rx_byte == chk) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timeout) begin
            load_error <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Directed frames against a byte-level frame model checked every cycle, plus literal spot checks.
module tb_uart_load_ctrl;

  localparam int TO    = 100;
  localparam int BYTES = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold, load_done, load_error, busy;

  uart_load_ctrl #(.ADDR_W(8), .WORD_W(16), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error), .busy(busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: tracks position within the frame in bytes, not controller states.
  logic        m_prev = 1'b1;
  bit          in_frame = 0;
  int          pos = 0, n = 0, silence = 0;
  logic [7:0]  x = '0;
  logic [15:0] word = '0;
  logic        e_we = 0, e_hold = 1, e_done = 0, e_err = 0, e_busy = 0;
  logic [7:0]  e_addr = '0;
  logic [15:0] e_wdata = '0;

  always @(posedge clock or posedge reset) begin
    logic acc;
    int lane;
    if (reset) begin
      m_prev = 1'b1; in_frame = 0; pos = 0; silence = 0;
      e_we = 0; e_hold = 1; e_done = 0; e_err = 0; e_busy = 0; e_addr = '0; e_wdata = '0;
    end else begin
      acc = rx_ready && !m_prev;
      m_prev = rx_ready;
      e_we = 0;
      e_done = 0;
      if (!in_frame) begin
        if (acc && rx_byte == 8'hA5) begin
          in_frame = 1; pos = 0; silence = 0; e_err = 0; e_hold = 1;
        end
      end else if (acc) begin
        silence = 0;
        if (pos == 0) begin
          n = int'(rx_byte);
          x = rx_byte;
        end else if (pos <= n * BYTES) begin
          x = x ^ rx_byte;
          lane = (pos - 1) % BYTES;
          word[lane*8 +: 8] = rx_byte;
          if (lane == BYTES - 1) begin
            e_we = 1;
            e_addr = 8'((pos - 1) / BYTES);
            e_wdata = word;
          end
        end else begin
          if (rx_byte == x) begin e_done = 1; e_hold = 0; end
          else e_err = 1;
          in_frame = 0;
        end
        pos++;
      end else begin
        silence++;
        if (silence >= TO) begin e_err = 1; in_frame = 0; end
      end
      e_busy = in_frame;
    end
  end

  always @(negedge clock) begin
    cmp("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we) begin
      cmp("mem_addr", 32'(mem_addr), 32'(e_addr));
      cmp("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
    cmp("cpu_hold", 32'(cpu_hold), 32'(e_hold));
    cmp("load_done", 32'(load_done), 32'(e_done));
    cmp("load_error", 32'(load_error), 32'(e_err));
    cmp("busy", 32'(busy), 32'(e_busy));
  end

  logic [23:0] we_q[$];
  int done_cnt = 0;
  always @(negedge clock) begin
    if (mem_we === 1'b1) we_q.push_back({mem_addr, mem_wdata});
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_byte  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clock);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  logic [7:0] fr[$];
  task automatic send_frame(input int gap);
    foreach (fr[i]) send_byte(fr[i], 1, gap);
  endtask

  task automatic chk_writes(input string nm, input int exp_n, input logic [23:0] w0, input logic [23:0] w1);
    cmp({nm, "_count"}, 32'(we_q.size()), 32'(exp_n));
    if (exp_n > 0) cmp({nm, "_w0"}, (we_q.size() > 0) ? 32'(we_q[0]) : 32'hFFFF_FFFF, 32'(w0));
    if (exp_n > 1) cmp({nm, "_w1"}, (we_q.size() > 1) ? 32'(we_q[1]) : 32'hFFFF_FFFF, 32'(w1));
  endtask

  task automatic chk_reset_vals(input string nm);
    cmp({nm, "_we"}, 32'(mem_we), 0);
    cmp({nm, "_addr"}, 32'(mem_addr), 0);
    cmp({nm, "_wdata"}, 32'(mem_wdata), 0);
    cmp({nm, "_hold"}, 32'(cpu_hold), 1);
    cmp({nm, "_done"}, 32'(load_done), 0);
    cmp({nm, "_err"}, 32'(load_error), 0);
    cmp({nm, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int d0;
    rx_byte  = 8'h00;
    rx_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");

    // A level already high when reset releases is not a byte.
    rx_byte = 8'hA5; rx_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (4) @(negedge clock);
    cmp("level_at_release_busy", 32'(busy), 0);
    rx_ready = 1'b0;
    repeat (2) @(negedge clock);

    // Good two-word load.
    fr = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    send_frame(4);
    repeat (4) @(negedge clock);
    chk_writes("good", 2, 24'h00_1234, 24'h01_5678);
    cmp("good_done", 32'(done_cnt), 1);
    cmp("good_hold", 32'(cpu_hold), 0);
    cmp("good_err", 32'(load_error), 0);
    cmp("good_busy", 32'(busy), 0);

    // Bad checksum, bytes only two cycles apart.
    we_q.delete();
    fr = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B};
    send_frame(1);
    repeat (4) @(negedge clock);
    chk_writes("badchk", 2, 24'h00_1234, 24'h01_5678);
    cmp("badchk_done", 32'(done_cnt), 1);
    cmp("badchk_hold", 32'(cpu_hold), 1);
    cmp("badchk_err", 32'(load_error), 1);

    // New start clears the error; next bytes land exactly on the timeout terminal count.
    we_q.delete();
    send_byte(8'hA5, 1, 0);
    cmp("restart_err", 32'(load_error), 0);
    cmp("restart_busy", 32'(busy), 1);
    repeat (99) @(negedge clock);
    send_byte(8'h01, 1, 99);
    send_byte(8'h34, 1, 0);
    cmp("edge_byte_busy", 32'(busy), 1);
    repeat (95) @(negedge clock);
    cmp("pre_timeout_busy", 32'(busy), 1);
    cmp("pre_timeout_err", 32'(load_error), 0);
    repeat (10) @(negedge clock);
    cmp("timeout_err", 32'(load_error), 1);
    cmp("timeout_busy", 32'(busy), 0);
    cmp("timeout_hold", 32'(cpu_hold), 1);
    chk_writes("timeout", 0, 24'h0, 24'h0);

    // Junk in IDLE, then a start byte held for five cycles, then an empty load.
    send_byte(8'h00, 1, 3);
    send_byte(8'hFF, 1, 3);
    send_byte(8'h5A, 1, 3);
    cmp("junk_busy", 32'(busy), 0);
    cmp("junk_err", 32'(load_error), 1);
    send_byte(8'hA5, 5, 3);
    cmp("held_start_busy", 32'(busy), 1);
    cmp("held_start_err", 32'(load_error), 0);
    d0 = done_cnt;
    send_byte(8'h00, 1, 3);
    send_byte(8'h00, 1, 3);
    repeat (3) @(negedge clock);
    cmp("empty_done", 32'(done_cnt - d0), 1);
    cmp("empty_hold", 32'(cpu_hold), 0);
    chk_writes("empty", 0, 24'h0, 24'h0);

    // Reset in the middle of a frame, then a full reload from address 0.
    fr = '{8'hA5, 8'h02, 8'h34};
    send_frame(3);
    cmp("midframe_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midreset");
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    we_q.delete();
    d0 = done_cnt;
    fr = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    send_frame(3);
    repeat (4) @(negedge clock);
    chk_writes("reload", 2, 24'h00_1234, 24'h01_5678);
    cmp("reload_done", 32'(done_cnt - d0), 1);
    cmp("reload_hold", 32'(cpu_hold), 0);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
